// File: rtl/riscv_csr_pkg.sv
// Shared CSR addresses, Zicsr operation encodings and mstatus bit positions.
package riscv_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    // Full funct3 encodings; bit 2 selects the immediate form.
    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    // Operation kind from funct3[1:0]; 00 is not a Zicsr operation.
    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;

    function automatic logic [31:0] csr_apply_op(input csr_op_e op,
                                                 input logic [31:0] cur,
                                                 input logic [31:0] operand);
        case (op)
            CSR_OP_RW: return operand;
            CSR_OP_RS: return cur | operand;
            CSR_OP_RC: return cur & ~operand;
            default:   return cur;
        endcase
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit counter with increment enable and independent 32-bit half writes.
// A write to one half replaces that half and freezes the other for the cycle.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc_en,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] count
);
    logic [31:0] lo_q;
    logic [31:0] hi_q;
    logic [63:0] inc_val;

    assign inc_val = {hi_q, lo_q} + {63'b0, inc_en};
    assign count   = {hi_q, lo_q};

    // Count with natural 64-bit wrap unless a half is being written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_q <= '0;
            hi_q <= '0;
        end else begin
            if (wr_lo)
                lo_q <= wdata;
            else if (!wr_hi)
                lo_q <= inc_val[31:0];

            if (wr_hi)
                hi_q <= wdata;
            else if (!wr_lo)
                hi_q <= inc_val[63:32];
        end
    end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: Zicsr read/modify/write, trap entry, MRET and
// the cycle/instret counters.
module csr_file
    import riscv_csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
    parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        csr_write_enable,
    input  logic [11:0] csr_addr,
    input  logic [2:0]  csr_funct3,
    input  logic [4:0]  csr_imm,
    input  logic [4:0]  rs1_addr,
    input  logic [31:0] rs1_data,
    input  logic        instr_retire,
    input  logic        trap_valid,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic        mret,
    output logic [31:0] csr_rdata,
    output logic [31:0] mtvec_out,
    output logic [31:0] mepc_out,
    output logic        mie_out,
    output logic        illegal_csr
);
    logic        mie_q;
    logic        mpie_q;
    logic [31:0] mtvec_q;
    logic [31:0] mscratch_q;
    logic [31:0] mepc_q;
    logic [31:0] mcause_q;
    logic [63:0] mcycle;
    logic [63:0] minstret;

    logic [31:0] mstatus_val;
    logic [31:0] old_val;
    logic [31:0] src;
    logic [31:0] new_val;
    logic        addr_hit;
    logic        op_valid;
    logic        do_write;
    logic        read_only;
    logic        wr_en;
    csr_op_e     op;

    // Architectural view of mstatus: only MIE and MPIE are implemented.
    always_comb begin
        mstatus_val                   = '0;
        mstatus_val[MSTATUS_MIE_BIT]  = mie_q;
        mstatus_val[MSTATUS_MPIE_BIT] = mpie_q;
    end

    // Address decode and pre-update read value.
    always_comb begin
        old_val  = '0;
        addr_hit = 1'b1;
        case (csr_addr)
            CSR_MSTATUS:               old_val = mstatus_val;
            CSR_MTVEC:                 old_val = mtvec_q;
            CSR_MSCRATCH:              old_val = mscratch_q;
            CSR_MEPC:                  old_val = mepc_q;
            CSR_MCAUSE:                old_val = mcause_q;
            CSR_MCYCLE,   CSR_CYCLE:   old_val = mcycle[31:0];
            CSR_MCYCLEH,  CSR_CYCLEH:  old_val = mcycle[63:32];
            CSR_MINSTRET, CSR_INSTRET: old_val = minstret[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: old_val = minstret[63:32];
            CSR_MHARTID:               old_val = HART_ID;
            default:                   addr_hit = 1'b0;
        endcase
    end

    // Operand selection, write suppression and legality.
    always_comb begin
        op          = csr_op_e'(csr_funct3[1:0]);
        op_valid    = (op != CSR_OP_NONE);
        src         = csr_funct3[2] ? {27'b0, csr_imm} : rs1_data;
        // Set/clear with a zero source register/immediate is a pure read.
        do_write    = (op == CSR_OP_RW) ||
                      (csr_funct3[2] ? (csr_imm != 5'd0) : (rs1_addr != 5'd0));
        read_only   = (csr_addr[11:10] == 2'b11);
        illegal_csr = csr_write_enable &&
                      (!addr_hit || !op_valid || (do_write && read_only));
        csr_rdata   = (csr_write_enable && !illegal_csr) ? old_val : '0;
        new_val     = csr_apply_op(op, old_val, src);
        // A trap discards the whole CSR write.
        wr_en       = csr_write_enable && !illegal_csr && do_write && !trap_valid;
    end

    // mstatus: trap beats mret beats a software write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie_q  <= 1'b0;
            mpie_q <= 1'b0;
        end else if (trap_valid) begin
            mpie_q <= mie_q;
            mie_q  <= 1'b0;
        end else if (mret) begin
            mie_q  <= mpie_q;
            mpie_q <= 1'b1;
        end else if (wr_en && csr_addr == CSR_MSTATUS) begin
            mie_q  <= new_val[MSTATUS_MIE_BIT];
            mpie_q <= new_val[MSTATUS_MPIE_BIT];
        end
    end

    // mepc and mcause are loaded by traps; otherwise software-writable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mepc_q   <= '0;
            mcause_q <= '0;
        end else if (trap_valid) begin
            mepc_q   <= {trap_pc[31:1], 1'b0};
            mcause_q <= trap_cause;
        end else if (wr_en) begin
            if (csr_addr == CSR_MEPC)
                mepc_q <= {new_val[31:1], 1'b0};
            if (csr_addr == CSR_MCAUSE)
                mcause_q <= new_val;
        end
    end

    // mtvec and mscratch change only through software writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtvec_q    <= {MTVEC_RESET[31:2], 2'b00};
            mscratch_q <= '0;
        end else if (wr_en) begin
            if (csr_addr == CSR_MTVEC)
                mtvec_q <= {new_val[31:2], 2'b00};
            if (csr_addr == CSR_MSCRATCH)
                mscratch_q <= new_val;
        end
    end

    csr_counter64 u_mcycle (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_en (1'b1),
        .wr_lo  (wr_en && csr_addr == CSR_MCYCLE),
        .wr_hi  (wr_en && csr_addr == CSR_MCYCLEH),
        .wdata  (new_val),
        .count  (mcycle)
    );

    csr_counter64 u_minstret (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_en (instr_retire),
        .wr_lo  (wr_en && csr_addr == CSR_MINSTRET),
        .wr_hi  (wr_en && csr_addr == CSR_MINSTRETH),
        .wdata  (new_val),
        .count  (minstret)
    );

    assign mtvec_out = mtvec_q;
    assign mepc_out  = mepc_q;
    assign mie_out   = mie_q;

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: directed sequences plus randomized
// traffic compared every cycle against a behavioural model.
module tb_csr_file;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        csr_write_enable;
    logic [11:0] csr_addr;
    logic [2:0]  csr_funct3;
    logic [4:0]  csr_imm;
    logic [4:0]  rs1_addr;
    logic [31:0] rs1_data;
    logic        instr_retire;
    logic        trap_valid;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic        mret;
    logic [31:0] csr_rdata;
    logic [31:0] mtvec_out;
    logic [31:0] mepc_out;
    logic        mie_out;
    logic        illegal_csr;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    localparam logic [31:0] TB_HART = 32'h0000_0005;

    csr_file #(.MTVEC_RESET(32'h0000_0100), .HART_ID(TB_HART)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .csr_write_enable (csr_write_enable),
        .csr_addr         (csr_addr),
        .csr_funct3       (csr_funct3),
        .csr_imm          (csr_imm),
        .rs1_addr         (rs1_addr),
        .rs1_data         (rs1_data),
        .instr_retire     (instr_retire),
        .trap_valid       (trap_valid),
        .trap_cause       (trap_cause),
        .trap_pc          (trap_pc),
        .mret             (mret),
        .csr_rdata        (csr_rdata),
        .mtvec_out        (mtvec_out),
        .mepc_out         (mepc_out),
        .mie_out          (mie_out),
        .illegal_csr      (illegal_csr)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic        m_mie = 0, m_mpie = 0;
    logic [31:0] m_mtvec = 32'h100, m_mscratch = 0, m_mepc = 0, m_mcause = 0;
    logic [63:0] m_cycle = 0, m_instret = 0;

    function automatic bit m_exists(input logic [11:0] a);
        case (a)
            12'h300, 12'h305, 12'h340, 12'h341, 12'h342,
            12'hB00, 12'hB80, 12'hB02, 12'hB82,
            12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hF14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300:          return {24'b0, m_mpie, 3'b0, m_mie, 3'b0};
            12'h305:          return m_mtvec;
            12'h340:          return m_mscratch;
            12'h341:          return m_mepc;
            12'h342:          return m_mcause;
            12'hB00, 12'hC00: return m_cycle[31:0];
            12'hB80, 12'hC80: return m_cycle[63:32];
            12'hB02, 12'hC02: return m_instret[31:0];
            12'hB82, 12'hC82: return m_instret[63:32];
            12'hF14:          return TB_HART;
            default:          return 32'h0;
        endcase
    endfunction

    function automatic bit m_writes();
        if (csr_funct3[1:0] == 2'b01) return 1'b1;
        return csr_funct3[2] ? (csr_imm != 0) : (rs1_addr != 0);
    endfunction

    function automatic bit m_illegal();
        if (!csr_write_enable) return 1'b0;
        if (!m_exists(csr_addr)) return 1'b1;
        if (csr_funct3[1:0] == 2'b00) return 1'b1;
        return m_writes() && (csr_addr[11:10] == 2'b11);
    endfunction

    function automatic logic [31:0] m_rdata();
        if (!csr_write_enable || m_illegal()) return 32'h0;
        return m_read(csr_addr);
    endfunction

    function automatic logic [31:0] m_newval();
        logic [31:0] s, o;
        s = csr_funct3[2] ? {27'b0, csr_imm} : rs1_data;
        o = m_read(csr_addr);
        case (csr_funct3[1:0])
            2'b01:   return s;
            2'b10:   return o | s;
            default: return o & ~s;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic        wr, old_mie, old_mpie;
        logic [31:0] nv;
        logic [63:0] nc, ni;
        if (!rst_n) begin
            m_mie = 0; m_mpie = 0; m_mtvec = 32'h100; m_mscratch = 0;
            m_mepc = 0; m_mcause = 0; m_cycle = 0; m_instret = 0;
        end else begin
            old_mie  = m_mie;
            old_mpie = m_mpie;
            nc = m_cycle + 64'd1;
            ni = m_instret + (instr_retire ? 64'd1 : 64'd0);
            wr = csr_write_enable && !m_illegal() && m_writes() && !trap_valid;
            nv = m_newval();
            if (wr) begin
                case (csr_addr)
                    12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                    12'h305: m_mtvec = nv & 32'hFFFF_FFFC;
                    12'h340: m_mscratch = nv;
                    12'h341: m_mepc = nv & 32'hFFFF_FFFE;
                    12'h342: m_mcause = nv;
                    12'hB00: nc = {m_cycle[63:32], nv};
                    12'hB80: nc = {nv, m_cycle[31:0]};
                    12'hB02: ni = {m_instret[63:32], nv};
                    12'hB82: ni = {nv, m_instret[31:0]};
                    default: ;
                endcase
            end
            if (trap_valid) begin
                m_mepc   = trap_pc & 32'hFFFF_FFFE;
                m_mcause = trap_cause;
                m_mpie   = old_mie;
                m_mie    = 1'b0;
            end else if (mret) begin
                m_mie  = old_mpie;
                m_mpie = 1'b1;
            end
            m_cycle   = nc;
            m_instret = ni;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_rdata",   csr_rdata,          m_rdata());
            check("model_illegal", {31'b0, illegal_csr}, {31'b0, m_illegal()});
            check("model_mtvec",   mtvec_out,          m_mtvec);
            check("model_mepc",    mepc_out,           m_mepc);
            check("model_mie",     {31'b0, mie_out},   {31'b0, m_mie});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        csr_write_enable = 0; csr_addr = 0; csr_funct3 = 0; csr_imm = 0;
        rs1_addr = 0; rs1_data = 0; instr_retire = 0; trap_valid = 0;
        trap_cause = 0; trap_pc = 0; mret = 0;
    endtask

    task automatic set_op(input logic [2:0] f3, input logic [11:0] a,
                          input logic [4:0] ra, input logic [31:0] rd, input logic [4:0] imm);
        csr_write_enable = 1; csr_funct3 = f3; csr_addr = a;
        rs1_addr = ra; rs1_data = rd; csr_imm = imm;
    endtask

    // Called at posedge+1 with inputs applied; samples at the negedge.
    task automatic run_cycle(output logic [31:0] rd, output logic ill);
        @(negedge clk);
        rd  = csr_rdata;
        ill = illegal_csr;
        @(posedge clk);
        #1;
        idle();
    endtask

    logic [31:0] rd;
    logic        ill;
    logic [11:0] addr_list [15] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342,
                                    12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00,
                                    12'hC80, 12'hC02, 12'hC82, 12'hF14, 12'h7C0};

    initial begin
        idle();
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1;
        check("rst_mtvec", mtvec_out, 32'h100);
        check("rst_mepc",  mepc_out,  32'h0);
        check("rst_mie",   {31'b0, mie_out}, 32'h0);
        rst_n = 1;

        // Reset sequence
        set_op(3'b010, 12'h305, 5'd0, 32'h0, 5'd0);
        run_cycle(rd, ill);
        check("rst_read_mtvec", rd, 32'h100);
        set_op(3'b010, 12'hB00, 5'd0, 32'h0, 5'd0);
        run_cycle(rd, ill);
        check("rst_read_mcycle", rd, 32'd1);

        // RW / RS / RC on mscratch
        set_op(3'b001, 12'h340, 5'd1, 32'hA5A5_0000, 5'd0);
        run_cycle(rd, ill);
        check("rw_old", rd, 32'h0);
        set_op(3'b010, 12'h340, 5'd2, 32'h0000_00FF, 5'd0);
        run_cycle(rd, ill);
        check("rs_old", rd, 32'hA5A5_0000);
        set_op(3'b011, 12'h340, 5'd3, 32'hA500_0000, 5'd0);
        run_cycle(rd, ill);
        check("rc_old", rd, 32'hA5A5_00FF);
        set_op(3'b010, 12'h340, 5'd0, 32'hFFFF_FFFF, 5'd0);
        run_cycle(rd, ill);
        check("final_scratch", rd, 32'h00A5_00FF);

        // Write suppression and illegal accesses
        set_op(3'b010, 12'hC00, 5'd0, 32'h1234, 5'd0);
        run_cycle(rd, ill);
        check("ro_rs_x0_ill", {31'b0, ill}, 32'h0);
        set_op(3'b001, 12'hC00, 5'd1, 32'h1234, 5'd0);
        run_cycle(rd, ill);
        check("ro_rw_ill", {31'b0, ill}, 32'h1);
        check("ro_rw_rdata", rd, 32'h0);
        set_op(3'b010, 12'h7C0, 5'd0, 32'h0, 5'd0);
        run_cycle(rd, ill);
        check("unimpl_ill", {31'b0, ill}, 32'h1);
        check("unimpl_rdata", rd, 32'h0);
        set_op(3'b000, 12'h340, 5'd1, 32'h5, 5'd0);
        run_cycle(rd, ill);
        check("f3_000_ill", {31'b0, ill}, 32'h1);
        set_op(3'b010, 12'hF14, 5'd0, 32'h0, 5'd0);
        run_cycle(rd, ill);
        check("hartid", rd, 32'h5);

        // Trap and return
        set_op(3'b110, 12'h300, 5'd0, 32'h0, 5'd8);
        run_cycle(rd, ill);
        check("mie_set", {31'b0, mie_out}, 32'h1);
        trap_valid = 1; trap_cause = 32'd11; trap_pc = 32'h0000_2003;
        run_cycle(rd, ill);
        check("trap_mepc", mepc_out, 32'h2002);
        check("trap_mie",  {31'b0, mie_out}, 32'h0);
        set_op(3'b010, 12'h342, 5'd0, 32'h0, 5'd0);
        run_cycle(rd, ill);
        check("trap_mcause", rd, 32'd11);
        set_op(3'b010, 12'h300, 5'd0, 32'h0, 5'd0);
        run_cycle(rd, ill);
        check("trap_mstatus", rd, 32'h80);
        mret = 1;
        run_cycle(rd, ill);
        check("mret_mie", {31'b0, mie_out}, 32'h1);

        // Trap beats a simultaneous mepc write
        set_op(3'b001, 12'h341, 5'd1, 32'h1234, 5'd0);
        trap_valid = 1; trap_cause = 32'd2; trap_pc = 32'h0000_4000;
        run_cycle(rd, ill);
        check("trap_prio_mepc", mepc_out, 32'h4000);

        // mcycle wrap
        set_op(3'b001, 12'hB80, 5'd1, 32'hFFFF_FFFF, 5'd0);
        run_cycle(rd, ill);
        set_op(3'b001, 12'hB00, 5'd1, 32'hFFFF_FFFE, 5'd0);
        run_cycle(rd, ill);
        repeat (2) run_cycle(rd, ill);
        set_op(3'b010, 12'hB00, 5'd0, 32'h0, 5'd0);
        run_cycle(rd, ill);
        check("wrap_lo", rd, 32'h0);
        set_op(3'b010, 12'hB80, 5'd0, 32'h0, 5'd0);
        run_cycle(rd, ill);
        check("wrap_hi", rd, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            csr_write_enable = ($urandom_range(0, 9) < 6);
            csr_addr   = ($urandom_range(0, 7) == 0) ? 12'($urandom)
                                                    : addr_list[$urandom_range(0, 14)];
            csr_funct3 = 3'($urandom);
            csr_imm    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            rs1_addr   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            rs1_data   = $urandom;
            instr_retire = 1'($urandom);
            trap_valid = ($urandom_range(0, 15) == 0);
            trap_cause = $urandom;
            trap_pc    = $urandom;
            mret       = ($urandom_range(0, 15) == 0);
            @(posedge clk);
            #1;
        end
        idle();

        // Reset mid-write discards the pending write
        set_op(3'b001, 12'h340, 5'd1, 32'hDEAD_BEEF, 5'd0);
        #2;
        rst_n = 0;
        @(posedge clk);
        #1;
        idle();
        check("midrst_mtvec", mtvec_out, 32'h100);
        rst_n = 1;
        set_op(3'b010, 12'h340, 5'd0, 32'h0, 5'd0);
        run_cycle(rd, ill);
        check("midrst_scratch", rd, 32'h0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
Parameters:
- REQ-001 The block SHALL have parameter MTVEC_RESET, default 32'h0000_0100, giving the reset value of mtvec.
- REQ-002 The block SHALL have parameter HART_ID, default 32'h0000_0000, giving the read-only value of mhartid.

Ports:
- REQ-003 The block SHALL use one clock and an asynchronous active-low reset.
- REQ-004 clk  input  1  the single clock; all state updates on the rising edge.
- REQ-005 rst_n  input  1  asynchronous active-low reset.
- REQ-006 csr_write_enable  input  1  Zicsr instruction present this cycle.
- REQ-007 csr_addr  input  12  CSR address.
- REQ-008 csr_funct3  input  3  operation selector: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
- REQ-009 csr_imm  input  5  zimm for the immediate forms.
- REQ-010 rs1_addr  input  5  rs1 index, used for write suppression.
- REQ-011 rs1_data  input  32  rs1 operand value.
- REQ-012 instr_retire  input  1  one instruction retires this cycle.
- REQ-013 trap_valid  input  1  take a trap (ECALL/EBREAK/illegal) this cycle.
- REQ-014 trap_cause  input  32  mcause value for the trap.
- REQ-015 trap_pc  input  32  PC of the trapping instruction.
- REQ-016 mret  input  1  MRET executes this cycle.
- REQ-017 csr_rdata  output  32  old CSR value, written to rd.
- REQ-018 mtvec_out  output  32  trap vector.
- REQ-019 mepc_out  output  32  return PC.
- REQ-020 mie_out  output  1  mstatus.MIE.
- REQ-021 illegal_csr  output  1  the access is illegal this cycle.

Function
- REQ-022 The block SHALL implement these CSRs: mstatus 0x300 (MIE bit 3 and MPIE bit 7 only, other bits read 0), mtvec 0x305 (bits [1:0] read 0), mscratch 0x340, mepc 0x341 (bit 0 reads 0), mcause 0x342, mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82, read-only cycle/cycleh 0xC00/0xC80, read-only instret/instreth 0xC02/0xC82, and read-only mhartid 0xF14.
- REQ-023 csr_rdata SHALL be combinational and SHALL return the pre-update value of the addressed CSR when csr_write_enable=1, and 0 otherwise.
- REQ-024 The source operand SHALL be rs1_data when funct3[2]=0 and {27'b0, csr_imm} when funct3[2]=1.
- REQ-025 The new value SHALL be: RW = src; RS = old | src; RC = old & ~src.
- REQ-026 For RS, RC, RSI and RCI, the block SHALL suppress the write when rs1_addr is 0 (register forms) or csr_imm is 0 (immediate forms); RW and RWI SHALL always write.
- REQ-027 A write SHALL take effect on the next rising edge, so the value is visible to the following instruction.
- REQ-028 mcycle (64-bit) SHALL increment every cycle and wrap from 2^64-1 to 0.
- REQ-029 minstret (64-bit) SHALL increment when instr_retire=1 and wrap from 2^64-1 to 0.
- REQ-030 A CSR write to a counter half SHALL override that cycle's increment for that half; the other half SHALL keep its value (no carry from the increment).
- REQ-031 illegal_csr SHALL be 1 when csr_write_enable=1 and either the address is unimplemented or an actual write (after REQ-026 suppression) targets a read-only address (csr_addr[11:10]=11).
- REQ-032 funct3 values 000 and 100 with csr_write_enable=1 SHALL set illegal_csr=1.
- REQ-033 When illegal_csr=1, the block SHALL perform no write and csr_rdata SHALL be 0.
- REQ-034 On a trap, the block SHALL set mepc to trap_pc with bit 0 cleared, mcause to trap_cause, MPIE to MIE, and MIE to 0.
- REQ-035 On mret, the block SHALL set MIE to MPIE and MPIE to 1.
- REQ-036 Priority SHALL be trap_valid > mret > CSR write; a lower-priority update in the same cycle SHALL be discarded for the fields a higher-priority event touches, and the CSR write SHALL be discarded entirely on a trap.
- REQ-037 The counters SHALL still increment during traps.
- REQ-038 mtvec_out, mepc_out and mie_out SHALL reflect registered state.

Reset
- REQ-039 When rst_n=0, all CSRs SHALL be cleared immediately without waiting for clk: mstatus 0, mscratch 0, mepc 0, mcause 0, all counters 0.
- REQ-040 When rst_n=0, mtvec SHALL be set to MTVEC_RESET with bits [1:0] cleared.
- REQ-041 Registered outputs SHALL take their reset values while rst_n=0; counting SHALL resume on the first rising edge after deassertion.
- REQ-042 A reset asserted mid-operation SHALL discard any pending write.

Structure
- REQ-043 The CSR address constants, funct3 operation encodings and mstatus bit positions SHALL live in a shared package, riscv_csr_pkg.
- REQ-044 The block SHALL instantiate one sub-module, csr_counter64, twice, for mcycle and minstret. csr_counter64 SHALL provide 64-bit increment-enable, separate lo/hi write ports, and wrap.

Verification
- REQ-045 Reset sequence: after reset release, a read of 0x305 SHALL return 0x100 and a read of 0xB00 SHALL return the number of cycles elapsed since release.
- REQ-046 RW/RS/RC sequence: CSRRW mscratch with 0xA5A5_0000 (read returns 0); then CSRRS with 0x0000_00FF (read returns 0xA5A5_0000); then CSRRC with 0xA500_0000 (read returns 0xA5A5_00FF); a final read SHALL return 0x00A5_00FF.
- REQ-047 Write suppression: CSRRS to cycle 0xC00 with rs1_addr=0 SHALL give illegal_csr=0; CSRRW to 0xC00 SHALL give illegal_csr=1 and leave state unchanged; an access to address 0x7C0 SHALL give illegal_csr=1 and csr_rdata=0.
- REQ-048 Trap/return: with MIE=1, trap_valid, cause=11 and pc=0x0000_2003 SHALL give mepc=0x2002, mcause=11, MIE=0 and MPIE=1; a following mret SHALL give MIE=1.
- REQ-049 Trap priority: trap_valid together with CSRRW mepc=0x1234 SHALL leave mepc at the trap_pc value.
- REQ-050 Counter wrap: write mcycleh=0xFFFF_FFFF and mcycle=0xFFFF_FFFE; after 2 cycles, mcycle and mcycleh SHALL both read 0.
